// File: rtl/svpwm_pkg.sv
// svpwm_pkg: shared types and constants for the SVPWM gate generator.
package svpwm_pkg;
    localparam int CNT_W_DEF = 16;
    localparam logic UP = 1'b0;
    localparam logic DOWN = 1'b1;
    typedef enum logic [1:0] {DEAD, HI, LO} phase_state_t;
endpackage

// File: rtl/pwm_deadband.sv
// pwm_deadband: one inverter leg; turns the raw demand into non-overlapping h/l gates
// with DT_CYCLES of both-off whenever the driven side changes.
module pwm_deadband
    import svpwm_pkg::*;
#(
    parameter int DT_CYCLES = 50
) (
    input  logic sys_clk,
    input  logic rst_n,
    input  logic en,
    input  logic raw,
    output logic h,
    output logic l
);
    localparam int DW = (DT_CYCLES > 1) ? $clog2(DT_CYCLES) : 1;
    localparam logic [DW-1:0] DT_LD = DW'(DT_CYCLES - 1);
    phase_state_t st, st_n;
    logic [DW-1:0] dt_cnt, dt_n, eff;
    logic raw_q;
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= DEAD;
            dt_cnt <= DT_LD;
            raw_q <= 1'b0;
            h <= 1'b0;
            l <= 1'b0;
        end else begin
            st <= st_n;
            dt_cnt <= dt_n;
            raw_q <= raw;
            h <= (st_n == HI);
            l <= (st_n == LO);
        end
    end
    // a change of raw while dead counts as the first cycle of a fresh gap
    always_comb begin
        eff = (raw != raw_q) ? DT_LD : dt_cnt;
        st_n = st;
        dt_n = DT_LD;
        if (!en) st_n = DEAD;
        else if (st == DEAD) begin
            if (eff == '0) st_n = raw ? HI : LO;
            else dt_n = eff - 1'b1;
        end else if (raw != (st == HI)) st_n = DEAD;
    end
endmodule

// File: rtl/svpwm_pwm_gen.sv
// svpwm_pwm_gen: center-aligned three-phase PWM with shadowed compares and sync/ovr strobes.
// Per-phase dead-band is built in when SVPWM_DEADTIME_EN is defined.
module svpwm_pwm_gen
    import svpwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int PERIOD = 2500,
    parameter int DT_CYCLES = 50
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             ld,
    input  logic [CNT_W-1:0] CP1,
    input  logic [CNT_W-1:0] CP2,
    input  logic [CNT_W-1:0] CP3,
    output logic [2:0]       pwm_h,
    output logic [2:0]       pwm_l,
    output logic             sync,
    output logic             ovr
);
    localparam logic [CNT_W-1:0] PER = CNT_W'(PERIOD);
    logic [CNT_W-1:0] cnt;
    logic dir;
    logic [2:0][CNT_W-1:0] cmp, pend_cp, cmp_n;
    logic pend, at_zero, xfer;
    logic [2:0] raw;

    if (DT_CYCLES < 1) begin : g_dt_chk
        $error("DT_CYCLES must be at least 1");
    end

    assign at_zero = en && (cnt == '0);
    assign xfer = at_zero && pend;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            dir <= UP;
        end else if (!en) begin
            cnt <= '0;
            dir <= UP;
        end else if (cnt == PER) begin
            cnt <= cnt - 1'b1;
            dir <= DOWN;
        end else if (cnt == '0) begin
            cnt <= cnt + 1'b1;
            dir <= UP;
        end else cnt <= (dir == UP) ? cnt + 1'b1 : cnt - 1'b1;
    end

    // a load landing on the zero cycle is not an overrun: the old value is consumed there
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_cp <= '0;
            cmp <= '0;
            pend <= 1'b0;
            ovr <= 1'b0;
            sync <= 1'b0;
        end else begin
            if (ld) pend_cp <= {CP3, CP2, CP1};
            if (xfer) cmp <= cmp_n;
            pend <= ld | (pend & ~xfer);
            ovr <= ld & pend & ~xfer;
            sync <= at_zero;
        end
    end

    always_comb begin
        cmp_n = '0;
        raw = '0;
        for (int i = 0; i < 3; i++) begin
            cmp_n[i] = (pend_cp[i] > PER) ? PER : pend_cp[i];
            raw[i] = (cmp[i] >= PER) ? 1'b1 : (cnt < cmp[i]);
        end
    end

`ifdef SVPWM_DEADTIME_EN
    for (genvar i = 0; i < 3; i++) begin : g_ph
        pwm_deadband #(.DT_CYCLES(DT_CYCLES)) u_db (
            .sys_clk(sys_clk),
            .rst_n(rst_n),
            .en(en),
            .raw(raw[i]),
            .h(pwm_h[i]),
            .l(pwm_l[i])
        );
    end
`else
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_h <= '0;
            pwm_l <= '0;
        end else begin
            pwm_h <= en ? raw : 3'b000;
            pwm_l <= en ? ~raw : 3'b000;
        end
    end
`endif
endmodule

// File: tb/tb_svpwm_pwm_gen.sv
// tb_svpwm_pwm_gen: directed stimulus, a period-position reference model checked every cycle,
// and literal duty/dead-time counts that pin the model.
module tb_svpwm_pwm_gen;
    localparam int P = 10;
    localparam int DT = 2;
    localparam int W = 16;
`ifdef SVPWM_DEADTIME_EN
    localparam int D = DT;
`else
    localparam int D = 0;
`endif
    logic sys_clk = 0, rst_n = 0, en = 0, ld = 0;
    logic [W-1:0] cp1 = 0, cp2 = 0, cp3 = 0;
    logic [2:0] pwm_h, pwm_l;
    logic sync, ovr;
    int checks = 0, errors = 0, cyc = 0, ovr_cnt = 0;

    svpwm_pwm_gen #(.CNT_W(W), .PERIOD(P), .DT_CYCLES(DT)) dut (
        .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .ld(ld),
        .CP1(cp1), .CP2(cp2), .CP3(cp3),
        .pwm_h(pwm_h), .pwm_l(pwm_l), .sync(sync), .ovr(ovr)
    );

    always #5 sys_clk = ~sys_clk;

    // model: p is the position within the 2*P-cycle period, carrier = triangle of p
    int p = 0, c = 0;
    int m_cmp[3] = '{0, 0, 0};
    int m_pnd[3] = '{0, 0, 0};
    int cpv[3] = '{0, 0, 0};
    int run[3] = '{0, 0, 0};
    bit lr[3] = '{0, 0, 0};
    bit r[3] = '{0, 0, 0};
    bit m_pf = 0, zero = 0;
    logic [2:0] e_h = 0, e_l = 0;
    logic e_sync = 0, e_ovr = 0;

    initial forever begin
        @(posedge sys_clk or negedge rst_n);
        if (!rst_n) begin
            p = 0; m_pf = 0; e_h = 0; e_l = 0; e_sync = 0; e_ovr = 0;
            for (int x = 0; x < 3; x++) begin
                m_cmp[x] = 0; m_pnd[x] = 0; run[x] = 0; lr[x] = 0;
            end
        end else begin
            c = (p <= P) ? p : 2 * P - p;
            zero = en && c == 0;
            cpv = '{int'(cp1), int'(cp2), int'(cp3)};
            for (int x = 0; x < 3; x++) begin
                r[x] = m_cmp[x] >= P || c < m_cmp[x];
`ifdef SVPWM_DEADTIME_EN
                // a side turns on once DT consecutive enabled dead cycles saw a constant demand
                run[x] = (en && !e_h[x] && !e_l[x]) ? ((run[x] > 0 && r[x] == lr[x]) ? run[x] + 1 : 1) : 0;
                if (!en) begin
                    e_h[x] = 0; e_l[x] = 0;
                end else if (e_h[x] || e_l[x]) begin
                    if (e_h[x] != r[x]) begin e_h[x] = 0; e_l[x] = 0; end
                end else if (run[x] >= DT) begin
                    e_h[x] = r[x]; e_l[x] = !r[x];
                end
`else
                e_h[x] = en && r[x];
                e_l[x] = en && !r[x];
`endif
                lr[x] = r[x];
            end
            e_sync = zero;
            e_ovr = ld && m_pf && !zero;
            if (zero && m_pf)
                for (int x = 0; x < 3; x++) m_cmp[x] = (m_pnd[x] > P) ? P : m_pnd[x];
            if (ld) m_pnd = cpv;
            m_pf = ld || (m_pf && !zero);
            p = en ? (p + 1) % (2 * P) : 0;
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", n, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge sys_clk);
        chk("pwm_h", 32'(pwm_h), 32'(e_h));
        chk("pwm_l", 32'(pwm_l), 32'(e_l));
        chk("sync", 32'(sync), 32'(e_sync));
        chk("ovr", 32'(ovr), 32'(e_ovr));
        chk("no_overlap", 32'(pwm_h & pwm_l), 0);
        if (ovr) ovr_cnt++;
    end

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_pos(input int t);
        int k = 0;
        while (p != t && k < 4 * P) begin tick(1); k++; end
        if (p != t) begin
            checks++; errors++;
            $display("FAIL wait_pos timeout target=%0d", t);
        end
    endtask

    task automatic wait_sync(output int t);
        int k = 0;
        do begin @(negedge sys_clk); k++; end while (!sync && k < 4 * P);
        t = cyc;
        if (!sync) begin
            checks++; errors++;
            $display("FAIL wait_sync timeout");
        end
    endtask

    task automatic count_win(input int ph, output int nh, output int nl, output int nd);
        nh = 0; nl = 0; nd = 0;
        repeat (2 * P) begin
            @(negedge sys_clk);
            nh += int'(pwm_h[ph]);
            nl += int'(pwm_l[ph]);
            nd += int'(!pwm_h[ph] && !pwm_l[ph]);
        end
    endtask

    task automatic wait_l0_fall();
        int k = 0;
        logic pl = 0;
        while (!(pl && !pwm_l[0]) && k < 4 * P) begin
            pl = pwm_l[0];
            @(negedge sys_clk);
            k++;
        end
        if (!(pl && !pwm_l[0])) begin
            checks++; errors++;
            $display("FAIL l0_fall timeout");
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int nh, nl, nd, t1, t2, o0, k;
        tick(2);
        chk("rst_h", 32'(pwm_h), 0);
        chk("rst_l", 32'(pwm_l), 0);
        chk("rst_sync", 32'(sync), 0);
        rst_n = 1;
        en = 1;
        // carrier alone: sync every 2*P cycles, every low side on
        wait_sync(t1);
        wait_sync(t2);
        chk("sync_gap", 32'(t2 - t1), 2 * P);
        chk("idle_h", 32'(pwm_h), 0);
        chk("idle_l", 32'(pwm_l), 3'b111);
        // shadow load mid-period takes effect only at the next zero
        wait_pos(5);
        cp1 = 5; cp2 = 0; cp3 = 12; ld = 1;
        tick(1);
        ld = 0;
        wait_pos(19);
        @(negedge sys_clk);
        chk("early_apply", 32'(pwm_h), 0);
        tick(2 * P + 6);
        // cnt<5 holds on 0..4 rising and 4..1 falling: 9 of 20 cycles
        count_win(0, nh, nl, nd);
        chk("a_high", 32'(nh), 9 - D);
        chk("a_low", 32'(nl), 11 - D);
        chk("a_dead", 32'(nd), 2 * D);
        count_win(1, nh, nl, nd);
        chk("b_high", 32'(nh), 0);
        chk("b_low", 32'(nl), 20);
        count_win(2, nh, nl, nd);
        chk("c_high", 32'(nh), 20);
        // low side falls, both off for the dead time, then the high side rises
        wait_l0_fall();
        nd = 0;
        while (!pwm_h[0] && !pwm_l[0] && nd < 10) begin
            nd++;
            @(negedge sys_clk);
        end
        chk("dead_len", 32'(nd), D);
        chk("h_after_dead", 32'(pwm_h[0]), 1);
        // two loads before a zero: one overrun, the later value wins
        tick(1);
        wait_pos(5);
        o0 = ovr_cnt;
        cp1 = 3; ld = 1;
        tick(1);
        ld = 0;
        tick(1);
        cp1 = 7; ld = 1;
        tick(1);
        ld = 0;
        tick(2 * P + 6);
        chk("ovr_once", 32'(ovr_cnt - o0), 1);
        count_win(0, nh, nl, nd);
        chk("a7_high", 32'(nh), 13 - D);
        chk("a7_low", 32'(nl), 7 - D);
        // load on the zero cycle: old pending applies now, new one a period later
        tick(1);
        wait_pos(5);
        cp1 = 2; ld = 1;
        tick(1);
        ld = 0;
        wait_pos(0);
        o0 = ovr_cnt;
        cp1 = 8; ld = 1;
        tick(1);
        ld = 0;
        @(negedge sys_clk);
        count_win(0, nh, nl, nd);
`ifndef SVPWM_DEADTIME_EN
        chk("a2_high", 32'(nh), 3);
`endif
        chk("zero_ld_no_ovr", 32'(ovr_cnt - o0), 0);
        tick(2 * P + 3);
        count_win(0, nh, nl, nd);
        chk("a8_high", 32'(nh), 15 - D);
        chk("a8_low", 32'(nl), 5 - D);
        // en dropped mid-period: all gates off next cycle
        tick(1);
        wait_pos(7);
        en = 0;
        tick(1);
        @(negedge sys_clk);
        chk("en_off_h", 32'(pwm_h), 0);
        chk("en_off_l", 32'(pwm_l), 0);
        tick(3);
        en = 1;
        tick(3 * P);
        // asynchronous reset in the middle of a dead band
        wait_l0_fall();
        #2;
        rst_n = 0;
        #1;
        chk("rst_mid_h", 32'(pwm_h), 0);
        chk("rst_mid_l", 32'(pwm_l), 0);
        chk("rst_mid_sync", 32'(sync), 0);
        tick(2);
        rst_n = 1;
        k = 0;
        tick(3 * P);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
